// File: rtl/mem_stage_if.sv
// Bus bundle between the MEM stage and its neighbours: stall vector, EX payload,
// SRAM read word, and the WB / forwarding outputs.
interface mem_stage_if;
  logic [5:0]  stall;
  logic [83:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_rf_bus
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_rf_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX payload, aligns/extends load data and
// holds the SRAM word across MEM stalls so a stalled load stays stable.
module mem_stage (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);

  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;

  logic [83:0] r_ex_to_mem_bus;
  logic [31:0] r_rdata_hold;
  logic        r_hold_valid;

  logic [1:0]  w_addr_lo;
  logic [5:0]  w_op;
  logic [31:0] w_pc;
  logic        w_sram_en;
  logic [3:0]  w_sram_wen;
  logic        w_sel_rf_res;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_ex_result;

  logic        w_hold_stage;
  logic        w_is_load;
  logic        w_capture;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;
  logic        w_unused_stall;

  assign {w_addr_lo, w_op, w_pc, w_sram_en, w_sram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr,
          w_ex_result} = r_ex_to_mem_bus;

  assign w_hold_stage   = (bus.stall[StallEx] == Stop) && (bus.stall[StallMem] == Stop);
  assign w_is_load      = w_sram_en && (w_sram_wen == 4'b0000) && w_sel_rf_res;
  assign w_capture      = w_hold_stage && w_is_load && !r_hold_valid;
  assign w_unused_stall = ^{bus.stall[5], bus.stall[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_to_mem_bus <= '0;
    end else if (bus.stall[StallEx] == Stop && bus.stall[StallMem] == NoStop) begin
      r_ex_to_mem_bus <= '0;
    end else if (bus.stall[StallEx] == NoStop) begin
      r_ex_to_mem_bus <= bus.ex_to_mem_bus;
    end
  end

  // Any cycle the register takes new content (or a bubble) invalidates the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_hold <= '0;
      r_hold_valid <= 1'b0;
    end else if (!w_hold_stage) begin
      r_hold_valid <= 1'b0;
    end else if (w_capture) begin
      r_rdata_hold <= bus.data_sram_rdata;
      r_hold_valid <= 1'b1;
    end
  end

  assign w_word = r_hold_valid ? r_rdata_hold : bus.data_sram_rdata;

  always_comb begin
    w_byte = w_word[7:0];
    unique case (w_addr_lo)
      2'b00: w_byte = w_word[7:0];
      2'b01: w_byte = w_word[15:8];
      2'b10: w_byte = w_word[23:16];
      2'b11: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  assign w_half = w_addr_lo[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load_data = w_word;
    if (w_is_load) begin
      case (w_op)
        OpLw:    w_load_data = w_word;
        OpLb:    w_load_data = {{24{w_byte[7]}}, w_byte};
        OpLbu:   w_load_data = {24'h0, w_byte};
        OpLh:    w_load_data = {{16{w_half[15]}}, w_half};
        OpLhu:   w_load_data = {16'h0, w_half};
        default: w_load_data = w_word;
      endcase
    end
  end

  assign w_rf_wdata = w_sel_rf_res ? w_load_data : w_ex_result;

  assign bus.mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
  assign bus.mem_to_rf_bus = {w_rf_we, w_rf_waddr, w_rf_wdata};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. It registers `ex_to_mem_bus`, takes load data from the data SRAM one cycle after EX issued the request, and aligns and extends it for LB/LBU/LH/LHU/LW. It holds the returned word while the stage is stalled. It drives the WB bus and the MEM-to-ID forwarding bus.

## Interface
- `EX_TO_MEM_WD`, 84: input bus width. Layout MSB→LSB:
  - mem_addr_lo[83:82]
  - ld_st_op[81:76]
  - ex_pc[75:44]
  - data_sram_en[43]
  - data_sram_wen[42:39]
  - sel_rf_res[38]
  - rf_we[37]
  - rf_waddr[36:32]
  - ex_result[31:0]
- `MEM_TO_WB_WD`, 70: output bus {mem_pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- `MEM_TO_RF_BUS`, 38: forwarding bus {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- `StallBus`, 6: stall vector. Bit 3 is EX, bit 4 is MEM. `Stop`=1, `NoStop`=0.

Ports:
- `clk` input 1: the single clock. Everything is on the rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `stall` input `StallBus`: pipeline stall vector.
- `ex_to_mem_bus` input `EX_TO_MEM_WD`: EX results and memory-op controls.
- `data_sram_rdata` input 32: SRAM read word. Valid in the cycle after EX asserted `data_sram_en` with `data_sram_wen`=0.
- `mem_to_wb_bus` output `MEM_TO_WB_WD`: payload to WB.
- `mem_to_rf_bus` output `MEM_TO_RF_BUS`: bypass to ID.

## Operation
Stage register `ex_to_mem_bus_r`, priority order:
1. `rst` → cleared to 0.
2. `stall[3]`=Stop and `stall[4]`=NoStop → cleared to 0 (bubble).
3. `stall[3]`=NoStop → loads `ex_to_mem_bus`.
4. Otherwise it holds.

Load decode uses `ld_st_op` (opcode). It applies only when data_sram_en=1, data_sram_wen=0 and sel_rf_res=1.
- 100011 LW: full word.
- 100000 LB, 100100 LBU: byte selected by mem_addr_lo (00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24]). Sign-extended for LB, zero-extended for LBU.
- 100001 LH, 100101 LHU: halfword selected by mem_addr_lo[1] only (0→[15:0], 1→[31:16]). Sign-extended for LH, zero-extended for LHU. mem_addr_lo[0] is ignored; there is no misalignment trap in this stage.
- Any other opcode with sel_rf_res=1 → full word.

rf_wdata is the aligned load data when sel_rf_res=1, otherwise ex_result. Stores (wen≠0) pass ex_result through; rf_we is normally 0 for them.

Read hold buffer (`rdata_hold` 32b, `hold_valid` 1b):
- The word source is `rdata_hold` when hold_valid=1, else `data_sram_rdata`.
- On a cycle where `stall[4]`=Stop, the stage holds a load, and hold_valid=0: capture `data_sram_rdata` into rdata_hold and set hold_valid.
- hold_valid clears on rst, and on any cycle where the stage register loads new content or a bubble. The clear has priority over capture.
- A held load therefore presents the same rf_wdata on every stall cycle, even though SRAM rdata changes.

Both output buses are formed combinationally from the stage register and the selected word:
- mem_pc = ex_pc.
- rf_we and rf_waddr pass through.
- mem_to_rf_bus carries the same we/waddr/wdata as mem_to_wb_bus.

## Timing
- Latency: one cycle. Bus contents accepted at edge N appear on the outputs after edge N; load data is the SRAM word presented in cycle N+1.
- Reset: both output buses are 0, and rdata_hold and hold_valid are 0.
- The bubble rule also zeroes rf_we, so a bubble never forwards or writes.
- Simultaneous advance and capture: advance wins. hold_valid ends at 0.
- `rst` asserted mid-stall: the register, hold_valid and both buses are 0 after the edge.
- `stall[3]`=Stop with `stall[4]`=Stop: the register holds and the hold buffer keeps its value.

## Test plan
- After reset, idle → both buses all-zero. Then ALU op: ex_result=0x1234_5678, rf_we=1, waddr=5, sel_rf_res=0 → next cycle mem_to_wb_bus wdata=0x12345678, waddr=5, we=1; mem_to_rf_bus equal.
- LB at addr_lo=11, rdata=0x80FF_0011 → wdata=0xFFFF_FF80. LBU with the same inputs → 0x0000_0080.
- LH at addr_lo=10, rdata=0x8001_7FFF → wdata=0xFFFF_8001. LHU → 0x0000_8001. LH at addr_lo=00 → 0x0000_7FFF.
- LW with rdata=0xDEAD_BEEF, stall[4]=Stop for 3 cycles while rdata changes to 0x0 → wdata stays 0xDEADBEEF all 3 cycles. On release, the next instruction is loaded and hold_valid=0.
- stall[3]=Stop, stall[4]=NoStop with a valid ALU op presented → bubble: all outputs 0, rf_we=0.
- rst asserted during a held load → next cycle buses and hold_valid are 0. A subsequent LW returns live rdata.
